// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Byte FIFO placed behind a UART receiver. The receiver holds in_valid high
//   from the end of one frame until the start of the next. Only the rising
//   edge of in_valid pushes a byte, so each received byte is captured once.
//   The read side is show-ahead: out_data presents the head entry whenever
//   out_valid is high, and reads as 8'h00 while the FIFO is empty.
//
// Parameters
//   DEPTH   number of byte entries (power of two, >= 2)
//   THRESH  fill level at which thresh_irq asserts (1..DEPTH)
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   in_valid      receiver byte-valid level
//   in_data       received byte, stable while in_valid is high
//   out_valid     head entry available (FIFO not empty)
//   out_ready     consumer accepts the head entry
//   out_data      head entry (show-ahead), 8'h00 when empty
//   level         current entry count, 0..DEPTH
//   full, empty   level == DEPTH, level == 0
//   overflow      sticky: a byte was dropped because the FIFO was full
//   clr_overflow  single-cycle clear of overflow (a same-cycle drop wins)
//   thresh_irq    level >= THRESH
//
// Configuration macro
//   UART_RX_FIFO_THRESH_EN  defined: thresh_irq is a register loaded with
//                           (next level >= THRESH), so it lines up with level.
//                           undefined: thresh_irq is tied low, THRESH unused.
//
// Handshake: a pop happens in a cycle where out_valid and out_ready are both
// high at the rising edge; out_valid never depends on out_ready, and
// out_ready has no effect while out_valid is low.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int THRESH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic                       thresh_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Elaboration-time parameter checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("uart_rx_fifo: THRESH must be in 1..DEPTH");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          in_valid_q;

  logic push;
  logic pop;
  logic accept;
  logic drop;

  // Status comes straight from the registered count only.
  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = ~empty;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign out_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    push       = in_valid & ~in_valid_q;
    pop        = out_valid & out_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    accept     = push & (~full | pop);
    drop       = push & full & ~pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

    case ({accept, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      // Starts high so a level already asserted at release is not a push.
      in_valid_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      in_valid_q <= in_valid;
    end
  end

  // Storage is not reset; level/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic thresh_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) thresh_q <= 1'b0;
    else       thresh_q <= (level_d >= LW'(THRESH));
  end

  assign thresh_irq = thresh_q;
`else
  assign thresh_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Bench for uart_rx_fifo with DEPTH = 4, THRESH = 3. A table of vectors
//   covers reset release with in_valid high, push/pop ordering and overflow;
//   hand sequences cover full push+pop, wrap-around and mid-run reset; a
//   random phase is checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DEPTH  = 4;
  localparam int THRESH = 3;
  localparam int LW     = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          clr_overflow = 1'b0;
  logic          thresh_irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .thresh_irq   (thresh_irq)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];   // bytes the FIFO should hold, head first
  logic       m_prev_iv;  // last in_valid level seen by the model
  logic       m_ovf;      // expected sticky overflow
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_thresh(input int lvl);
`ifdef UART_RX_FIFO_THRESH_EN
    return (lvl >= THRESH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_prev_iv = 1'b1;
    m_ovf     = 1'b0;
  endfunction

  // One clock of FIFO behaviour: a byte arrives on each in_valid rising edge,
  // the head leaves when the consumer is ready, a full FIFO keeps a new byte
  // only if it is losing one in the same cycle.
  function automatic void model_step(input logic iv, input logic [7:0] d,
                                     input logic rdy, input logic clr);
    int  sz   = exp_q.size();
    bit  push = iv && !m_prev_iv;
    bit  pop  = (sz > 0) && rdy;
    bit  lost = 1'b0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) exp_q.push_back(d);
      else                   lost = 1'b1;
    end
    if (clr)  m_ovf = 1'b0;
    if (lost) m_ovf = 1'b1;
    m_prev_iv = iv;
  endfunction

  task automatic check_model(input string tag);
    int sz = exp_q.size();
    chk({tag, "_level"},     32'(level),      32'(sz));
    chk({tag, "_empty"},     32'(empty),      32'(sz == 0));
    chk({tag, "_full"},      32'(full),       32'(sz == DEPTH));
    chk({tag, "_out_valid"}, 32'(out_valid),  32'(sz != 0));
    chk({tag, "_out_data"},  32'(out_data),   32'((sz != 0) ? exp_q[0] : 8'h00));
    chk({tag, "_overflow"},  32'(overflow),   32'(m_ovf));
    chk({tag, "_thresh"},    32'(thresh_irq), 32'(exp_thresh(sz)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic iv, input logic [7:0] d, input logic rdy,
                       input logic clr, input string tag);
    in_valid     = iv;
    in_data      = d;
    out_ready    = rdy;
    clr_overflow = clr;
    model_step(iv, d, rdy, clr);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic push_byte(input logic [7:0] d, input string tag);
    cycle(1'b1, d, 1'b0, 1'b0, tag);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_level"},     32'(level),      32'd0);
    chk({tag, "_empty"},     32'(empty),      32'd1);
    chk({tag, "_full"},      32'(full),       32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid),  32'd0);
    chk({tag, "_out_data"},  32'(out_data),   32'h00);
    chk({tag, "_overflow"},  32'(overflow),   32'd0);
    chk({tag, "_thresh"},    32'(thresh_irq), 32'd0);
  endtask

  task automatic do_reset(input logic iv_hold);
    reset        = 1'b1;
    in_valid     = iv_hold;
    in_data      = 8'h99;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("in_reset");
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         e_level;
    logic [7:0] e_data;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] rnd_data;
    logic       rnd_iv;
    logic       rnd_rdy;
    logic       rnd_clr;

    // Reset release with in_valid held high, then three frames 0x41..0x43,
    // drain, pop-on-empty, then fill to full, drop 0x14, drain, clear.
    vecs.push_back('{1'b1, 8'h99, 1'b0, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b0, 1, 8'h41, 1'b0});
    vecs.push_back('{1'b1, 8'h41, 1'b0, 1'b0, 1, 8'h41, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h41, 1'b0});
    vecs.push_back('{1'b1, 8'h42, 1'b0, 1'b0, 2, 8'h41, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 2, 8'h41, 1'b0});
    vecs.push_back('{1'b1, 8'h43, 1'b0, 1'b0, 3, 8'h41, 1'b0});
    vecs.push_back('{1'b1, 8'h43, 1'b1, 1'b0, 2, 8'h42, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h43, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{1'b1, 8'h10, 1'b0, 1'b0, 1, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 2, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 2, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 8'h12, 1'b0, 1'b0, 3, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 3, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 8'h13, 1'b0, 1'b0, 4, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4, 8'h10, 1'b0});
    vecs.push_back('{1'b1, 8'h14, 1'b0, 1'b0, 4, 8'h10, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 4, 8'h10, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 3, 8'h11, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h12, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h13, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0});

    // Reset with in_valid already high: must not be captured on release.
    do_reset(1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr, "vec_model");
      chk($sformatf("vec%0d_level", i),    32'(level),      32'(vecs[i].e_level));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data),   32'(vecs[i].e_data));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow),   32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_empty", i),    32'(empty),      32'(vecs[i].e_level == 0));
      chk($sformatf("vec%0d_full", i),     32'(full),       32'(vecs[i].e_level == DEPTH));
      chk($sformatf("vec%0d_thresh", i),   32'(thresh_irq), 32'(exp_thresh(vecs[i].e_level)));
    end

    // Full FIFO: push 0x55 with a pop in the same cycle is accepted.
    for (int k = 0; k < DEPTH; k++) push_byte(8'h20 + 8'(k), "fill_full");
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "full_push_pop");
    chk("full_push_pop_level", 32'(level), 32'(DEPTH));
    chk("full_push_pop_ovf",   32'(overflow), 32'd0);
    chk("full_push_pop_head",  32'(out_data), 32'h21);
    for (int k = 0; k < DEPTH - 1; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("last_entry_0x55", 32'(out_data), 32'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain_last");
    chk("drained_empty", 32'(empty), 32'd1);

    // Ten push/pop rounds with two entries in flight walk the pointers
    // around the ring several times.
    push_byte(8'h5F, "wrap_pre");
    for (int r = 0; r < 10; r++) begin
      cycle(1'b1, 8'h60 + 8'(r), 1'b0, 1'b0, "wrap_push");
      cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_pop");
      chk($sformatf("wrap%0d_head", r), 32'(out_data), 32'(8'h60 + 8'(r)));
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");

    // Reset asserted mid-run with a full FIFO discards everything at once.
    for (int k = 0; k < DEPTH; k++) push_byte(8'h30 + 8'(k), "pre_reset");
    chk("pre_reset_level", 32'(level), 32'(DEPTH));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "post_reset_idle");
    cycle(1'b1, 8'h7E, 1'b0, 1'b0, "post_reset_push");
    chk("post_reset_out_data", 32'(out_data), 32'h7E);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_reset_pop");

    // Random receiver traffic: in_valid stays high for a few cycles per
    // byte, the consumer alternates between slow and fast phases.
    rnd_iv   = 1'b0;
    rnd_data = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        rnd_iv = ~rnd_iv;
        if (rnd_iv) rnd_data = 8'($urandom_range(0, 255));
      end
      if (((c / 100) % 2) == 0) rnd_rdy = ($urandom_range(0, 5) == 0);
      else                      rnd_rdy = ($urandom_range(0, 1) == 0);
      rnd_clr = ($urandom_range(0, 19) == 0);
      cycle(rnd_iv, rnd_data, rnd_rdy, rnd_clr, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16, number of byte entries; power of two, minimum 2.
REQ-002 Parameter: THRESH, default 8, fill level at which the threshold flag asserts; range 1..DEPTH.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  receiver byte-valid level; stays high until the receiver's next frame starts.
REQ-006 Port: in_data  input  8  received byte, stable while in_valid is high.
REQ-007 Port: out_valid  output  1  head entry available (FIFO not empty).
REQ-008 Port: out_ready  input  1  consumer accepts the head entry.
REQ-009 Port: out_data  output  8  head entry (show-ahead).
REQ-010 Port: level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-011 Port: full  output  1  level == DEPTH.
REQ-012 Port: empty  output  1  level == 0.
REQ-013 Port: overflow  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-014 Port: clr_overflow  input  1  single-cycle clear of overflow.
REQ-015 Port: thresh_irq  output  1  level at or above THRESH (see Configuration).

Function
REQ-016 The block SHALL register in_valid into in_valid_q every cycle; push = in_valid & ~in_valid_q (rising edge), so each received byte is captured exactly once.
REQ-017 On push, in_data SHALL be written at the write pointer at the end of that cycle; it is visible on out_valid/out_data in the next cycle when the FIFO was empty.
REQ-018 pop = out_valid & out_ready; the read pointer advances at the end of that cycle; out_data SHALL then present the next entry with zero added latency.
REQ-019 out_data SHALL be 8'h00 while empty is high.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; level SHALL update by +1 on push only, -1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-021 Push while full with pop in the same cycle: the push SHALL be accepted; level stays DEPTH; no overflow.
REQ-022 Push while full without pop: the byte SHALL be dropped, the pointers and level SHALL stay unchanged, and overflow SHALL be set at the end of the cycle.
REQ-023 overflow SHALL stay set until clr_overflow; simultaneous set and clear: set wins.
REQ-024 Pop while empty cannot occur (out_valid low); out_ready while empty SHALL have no effect.
REQ-025 full, empty, out_valid and level SHALL be derived from registered pointer/count state, with no combinational path from in_valid or out_ready.

Reset
REQ-026 While reset is high, pointers, level and overflow SHALL be 0; empty = 1, full = 0, out_valid = 0, out_data = 0, thresh_irq = 0.
REQ-027 in_valid_q SHALL reset to 1, so an in_valid level already high at reset release is not captured.
REQ-028 Reset mid-operation SHALL discard all stored entries immediately; memory contents need not be cleared.

Configuration
REQ-029 Macro UART_RX_FIFO_THRESH_EN defined: thresh_irq is a register set to (next level >= THRESH) each cycle, so it tracks level with no extra cycle of lag.
REQ-030 Macro not defined: thresh_irq SHALL be tied to 0; THRESH SHALL be ignored; the port SHALL still exist.

Verification
REQ-031 Reset release with in_valid held high -> no push; level = 0, empty = 1.
REQ-032 Three in_valid rising edges with bytes 0x41, 0x42, 0x43 and out_ready = 0 -> level = 3; with out_ready = 1, out_data gives 0x41, 0x42, 0x43 on consecutive cycles, then empty = 1, out_data = 0x00.
REQ-033 DEPTH = 4: push 0x10..0x13, then push 0x14 with out_ready = 0 -> full = 1, overflow = 1, 0x14 dropped; pops return 0x10..0x13; clr_overflow -> overflow = 0.
REQ-034 DEPTH = 4, full: push 0x55 and pop in the same cycle -> level stays 4, overflow = 0; last pop returns 0x55; 10 push/pop rounds -> wrap-around preserves order.
REQ-035 UART_RX_FIFO_THRESH_EN, THRESH = 8: the 8th push -> thresh_irq = 1 the same cycle level = 8; one pop -> thresh_irq = 0. Without the macro -> thresh_irq stays 0.
REQ-036 Reset asserted at level = 5 -> level = 0, out_valid = 0 during reset; after release, a new push 0x7E -> out_data = 0x7E.
